// File: rtl/mux_2x1_if.sv
// mux_2x1_if: bundles the data-lane, select and result signals of mux_2x1.
// The master side drives sel/inputVal; the slave side (the mux) drives results.
// Build option: MUX2X1_PARITY_EN adds the y_par parity output.
interface mux_2x1_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic               sel;
  logic [2*WIDTH-1:0] inputVal;
  logic [WIDTH-1:0]   y;
  logic [WIDTH-1:0]   y_q;
  logic [CNT_W-1:0]   sel_toggles;
`ifdef MUX2X1_PARITY_EN
  logic               y_par;
`endif

  // Handshake: none. Inputs are accepted every cycle; there is no
  // valid/ready pair and no backpressure.
`ifdef MUX2X1_PARITY_EN
  modport master (output sel, output inputVal,
                  input  y, input y_q, input sel_toggles, input y_par);
  modport slave  (input  sel, input inputVal,
                  output y, output y_q, output sel_toggles, output y_par);
`else
  modport master (output sel, output inputVal,
                  input  y, input y_q, input sel_toggles);
  modport slave  (input  sel, input inputVal,
                  output y, output y_q, output sel_toggles);
`endif
endinterface

// File: rtl/mux_2x1.sv
// mux_2x1: 2:1 lane-select mux with combinational result y, registered copy
// y_q, and a saturating counter of sel changes observed at clk edges.
// Build option: define MUX2X1_PARITY_EN to add y_par = ^y_q (registered).
module mux_2x1 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  mux_2x1_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] w_lane0;
  logic [WIDTH-1:0] w_lane1;
  logic [WIDTH-1:0] w_y;
  logic             w_toggle;
  logic             w_cnt_sat;

  logic [WIDTH-1:0] r_y_q;
  logic             r_sel_prev;
  logic [CNT_W-1:0] r_sel_toggles;

  assign w_lane0 = bus.inputVal[WIDTH-1:0];
  assign w_lane1 = bus.inputVal[2*WIDTH-1:WIDTH];

  // The conditional operator keeps simulation X-merge: with an unknown sel,
  // bits where both lanes agree resolve, differing bits go X.
  assign w_y = bus.sel ? w_lane1 : w_lane0;

  assign w_toggle  = (bus.sel != r_sel_prev);
  assign w_cnt_sat = (r_sel_toggles == CNT_MAX);

  // Registered copy of the mux result, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_q <= '0;
    end else begin
      r_y_q <= w_y;
    end
  end

  // Track previous sel and count changes, holding at the maximum value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_prev    <= 1'b0;
      r_sel_toggles <= '0;
    end else begin
      r_sel_prev <= bus.sel;
      if (w_toggle && !w_cnt_sat) begin
        r_sel_toggles <= r_sel_toggles + 1'b1;
      end
    end
  end

`ifdef MUX2X1_PARITY_EN
  logic r_y_par;

  // Parity of the value being loaded into y_q, so it always matches y_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_par <= 1'b0;
    end else begin
      r_y_par <= ^w_y;
    end
  end

  assign bus.y_par = r_y_par;
`endif

  assign bus.y           = w_y;
  assign bus.y_q         = r_y_q;
  assign bus.sel_toggles = r_sel_toggles;

endmodule

// File: tb/tb_mux_2x1.sv
// tb_mux_2x1: directed checks of mux_2x1 across three instances:
// WIDTH=1/CNT_W=8, WIDTH=1/CNT_W=2 (saturation) and WIDTH=4.
// Build option: MUX2X1_PARITY_EN enables the y_par checks.
module tb_mux_2x1;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;

  mux_2x1_if #(.WIDTH(1), .CNT_W(8)) if1 ();
  mux_2x1_if #(.WIDTH(1), .CNT_W(2)) ifs ();
  mux_2x1_if #(.WIDTH(4), .CNT_W(8)) if4 ();

  mux_2x1 #(.WIDTH(1), .CNT_W(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  mux_2x1 #(.WIDTH(1), .CNT_W(2)) duts (.clk(clk), .rst_n(rst_n), .bus(ifs.slave));
  mux_2x1 #(.WIDTH(4), .CNT_W(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  // Clock: 10 ns period, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] tt_exp;
  logic [2:0] vec;
  logic [1:0] sat_exp [6];

  initial begin
    tt_exp     = 8'b1100_1010;
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3; sat_exp[5] = 2'd3;

    rst_n        = 1'b0;
    if1.sel      = 1'b0; if1.inputVal = 2'b00;
    ifs.sel      = 1'b0; ifs.inputVal = 2'b00;
    if4.sel      = 1'b0; if4.inputVal = 8'h00;

    // Reset state
    #2;
    check("rst_y_q",    32'(if1.y_q), 32'd0);
    check("rst_toggles", 32'(if1.sel_toggles), 32'd0);
    check("rst_sat_toggles", 32'(ifs.sel_toggles), 32'd0);
    check("rst_y_q_w4", 32'(if4.y_q), 32'd0);
`ifdef MUX2X1_PARITY_EN
    check("rst_y_par", 32'(if4.y_par), 32'd0);
`endif

    // Exhaustive WIDTH=1 sweep, held in reset: y must be valid regardless
    #98;
    for (int v = 0; v < 8; v++) begin
      vec = 3'(v);
      {if1.sel, if1.inputVal} = vec;
      #1;
      check($sformatf("tt_%0d", v), 32'(if1.y), 32'(tt_exp[vec]));
      #49;
    end
    check("tt_y_q_in_reset", 32'(if1.y_q), 32'd0);

    // Release reset with inputs at zero
    @(negedge clk);
    if1.sel = 1'b0; if1.inputVal = 2'b00;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_toggles", 32'(if1.sel_toggles), 32'd0);

    // Registered path: y immediate, y_q one edge later
    @(negedge clk);
    if1.sel = 1'b1; if1.inputVal = 2'b10;
    #1;
    check("reg_y_now",    32'(if1.y),   32'd1);
    check("reg_y_q_pre",  32'(if1.y_q), 32'd0);
    @(posedge clk); #1;
    check("reg_y_q_post", 32'(if1.y_q), 32'd1);
    check("first_toggle", 32'(if1.sel_toggles), 32'd1);

    // Build up sel_toggles to 5 with y held at 1
    @(negedge clk);
    if1.inputVal = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if1.sel = ~if1.sel;
      @(posedge clk); #1;
      check($sformatf("cnt_%0d", i + 2), 32'(if1.sel_toggles), 32'(i + 2));
    end
    check("pre_rst_y_q", 32'(if1.y_q), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("hold_toggles", 32'(if1.sel_toggles), 32'd5);

    // Async reset between edges
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_y_q",     32'(if1.y_q), 32'd0);
    check("arst_toggles", 32'(if1.sel_toggles), 32'd0);
    check("arst_y",       32'(if1.y), 32'd1);
    if1.inputVal = 2'b01;
    #1;
    check("arst_y_track", 32'(if1.y), 32'd0);

    // Release and exercise saturation on the CNT_W=2 instance
    @(negedge clk);
    rst_n   = 1'b1;
    if1.sel = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ifs.sel = ~ifs.sel;
      @(posedge clk); #1;
      check($sformatf("sat_%0d", i), 32'(ifs.sel_toggles), 32'(sat_exp[i]));
    end
    repeat (2) @(posedge clk);
    #1;
    check("sat_hold", 32'(ifs.sel_toggles), 32'd3);

    // WIDTH=4 lane selection
    @(negedge clk);
    if4.inputVal = 8'hA5; if4.sel = 1'b0;
    #1;
    check("w4_sel0", 32'(if4.y), 32'h5);
    if4.sel = 1'b1;
    #1;
    check("w4_sel1", 32'(if4.y), 32'hA);
    @(posedge clk); #1;
    check("w4_y_q", 32'(if4.y_q), 32'hA);

`ifdef MUX2X1_PARITY_EN
    @(negedge clk);
    if4.sel = 1'b0; if4.inputVal = 8'h07;
    @(posedge clk); #1;
    check("par_y_q_7", 32'(if4.y_q), 32'h7);
    check("par_odd",   32'(if4.y_par), 32'd1);
    @(negedge clk);
    if4.inputVal = 8'h06;
    @(posedge clk); #1;
    check("par_y_q_6", 32'(if4.y_q), 32'h6);
    check("par_even",  32'(if4.y_par), 32'd0);
`endif

    #20;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux_2x1.md
Name: mux_2x1

Overview:
- Two-input, one-select data multiplexer with a combinational output and a registered copy of that output.
- Also keeps a saturating count of select-line transitions for debug and visibility.
- Used as the leaf lane-select primitive in datapath steering logic; default WIDTH=1 gives the classic 1-bit 2:1 mux.

Parameters:
- WIDTH, 1, bits per data lane (>=1)
- CNT_W, 8, width of select-toggle counter (>=2)

Ports:
- clk  input  1  rising-edge clock for all registered state
- rst_n  input  1  asynchronous active-low reset
- sel  input  1  lane select; 0 = lane 0, 1 = lane 1
- inputVal  input  2*WIDTH  packed data lanes; lane 0 = inputVal[WIDTH-1:0], lane 1 = inputVal[2*WIDTH-1:WIDTH]
- y  output  WIDTH  combinational mux result
- y_q  output  WIDTH  y registered on clk
- sel_toggles  output  CNT_W  saturating count of sel value changes seen at clk edges

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-low, on rst_n.
- Combinational output:
  - y = sel ? lane1 : lane0.
  - Purely combinational, zero latency, independent of clk and rst_n; valid during reset.
  - WIDTH=1 truth table, with {sel, inputVal[1:0]} as a 3-bit value 0..7: y = 0,1,0,1,0,0,1,1.
  - If sel is X/Z and lane0 == lane1 bitwise, y equals that common value. Otherwise the bits where the lanes differ are X. Simulation only; no synthesis impact.
- Registered output:
  - y_q <= y on each rising clk edge: 1-cycle latency.
  - rst_n low asynchronously forces y_q = 0 and holds it until rst_n is high at a clk edge.
- Toggle counter:
  - Internal sel_prev register samples sel every clk edge.
  - sel_toggles increments by 1 on an edge where sel != sel_prev.
  - Saturates at 2^CNT_W-1: no wrap.
  - Reset clears sel_toggles = 0 and sel_prev = 0. A sel=1 on the first edge after reset therefore counts as a toggle.
- Reset mid-operation: all registered outputs clear immediately on rst_n falling edge; y keeps tracking its inputs.
- No handshakes, no backpressure; the block accepts new inputs every cycle.

Optional Feature:
- Macro: MUX2X1_PARITY_EN
- Defined:
  - Adds output port y_par (output, 1 bit) = XOR-reduction of y_q.
  - Registered in the same cycle as y_q; reset value 0.
- Undefined: no y_par port; all other behaviour identical.

Test Plan:
- Exhaustive WIDTH=1 sweep: drive {sel, inputVal} = 0..7, one value every 50 ns, after a 100 ns settle -> y = 0,1,0,1,0,0,1,1 respectively, within the same timestep.
- Registered path: clk period 10 ns, rst_n released, sel=1, inputVal=2'b10 -> y=1 immediately; y_q=1 after the next rising edge, and 0 before it.
- Async reset: with y_q=1 and sel_toggles=5, drop rst_n between edges -> y_q=0 and sel_toggles=0 at once, without a clock edge; y still tracks its inputs.
- Toggle saturation: CNT_W=2, toggle sel every cycle for 6 cycles -> sel_toggles = 1,2,3,3,3,3; holding sel constant leaves the count unchanged.
- WIDTH=4: inputVal=8'hA5 -> sel=0 gives y=4'h5, sel=1 gives y=4'hA.
- With MUX2X1_PARITY_EN defined, WIDTH=4, y_q=4'b0111 -> y_par=1; y_q=4'b0110 -> y_par=0.
